fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side controller for the team's synchronous FIFO. On a `start` command it drains a programmed number of words from the FIFO's read port (`rd_en`/`data_out`/`empty`/`underflow`) and re-presents them on a valid/ready stream. It hides the FIFO's one-cycle read latency behind a 2-entry output buffer. It never issues a read to an empty FIFO and never drops or reorders words under backpressure.

## Interface
- `FIFO_WIDTH`, 16, data width; must match the attached FIFO.
- `LEN_WIDTH`, 8, width of `burst_len` and of the remaining-word counter.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle command pulse; sampled only in IDLE.
- `burst_len`  in  LEN_WIDTH  number of words to drain; sampled with `start`.
- `fifo_rd_en`  out  1  read strobe to the FIFO; combinational from registered state, `fifo_empty` and `m_ready`.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data; valid in the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag; registered, arrives the cycle after `fifo_rd_en`.
- `m_data`  out  FIFO_WIDTH  stream data (head of the output buffer).
- `m_valid`  out  1  stream valid; equals `buf_count != 0`.
- `m_ready`  in  1  stream ready; a transfer (pop) occurs when `m_valid && m_ready`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a burst completes.
- `words_read`  out  16  count of stream transfers; wraps at 2^16; cleared only by `rst`.
- `err_underflow`  out  1  sticky; set if `fifo_underflow` is seen on an issued read; cleared only by `rst`.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - `start=1` with `burst_len!=0`: load `remaining=burst_len` and go to RUN.
  - `start=1` with `burst_len==0`: go to DONE; no reads are issued.
- RUN:
  - `fifo_rd_en = !fifo_empty && (remaining > inflight) && (buf_count + inflight - pop < 2)`.
  - `inflight` (0/1) is the registered copy of `fifo_rd_en`.
- Capture, in the cycle after a read:
  - If `inflight && !fifo_underflow`: push `fifo_data_out` into the buffer and decrement `remaining`.
  - If `inflight && fifo_underflow`: drop the word, leave `remaining` unchanged, set `err_underflow`.
- Buffer: 2-entry register FIFO, in-order. Push and pop in the same cycle are allowed. Push into a full buffer is impossible by the credit rule.
- RUN → DONE when all of these hold in the same cycle: `remaining==0`, `inflight==0`, and (`buf_count==0`, or `buf_count==1 && pop`).
- DONE: `done=1` for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored.
- `remaining` arithmetic is unsigned LEN_WIDTH and never underflows: it is decremented only on capture, and a capture requires `remaining > 0` at issue.

## Timing
- Reset values: state IDLE, `fifo_rd_en=0`, `m_valid=0`, `m_data=0`, `busy=0`, `done=0`, `words_read=0`, `err_underflow=0`, `buf_count=0`, `inflight=0`, `remaining=0`.
- `rst` mid-burst: all of the above take their reset values on the next edge. Buffered and in-flight words are discarded.
- Latency:
  - `start` in cycle n puts the block in RUN in cycle n+1.
  - First `fifo_rd_en` is in cycle n+1 if the FIFO is not empty.
  - Captured at the end of cycle n+2; first `m_valid` in cycle n+3.
- Throughput: with `m_ready=1` and a non-empty FIFO, one read and one transfer per cycle.
- Backpressure: at most 2 words are buffered or in flight. With `m_ready=0`, at most 2 `fifo_rd_en` pulses occur.
- `fifo_empty` rising in RUN stops reads immediately in the same cycle; reads resume on the first cycle `fifo_empty=0`.
- `m_data` and `m_valid` are registered; `m_data` holds its value while `m_valid && !m_ready`.
- `words_read` increments on every pop, including on the edge into DONE. 0xFFFF+1 wraps to 0.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `start=1` → all outputs at their reset values, no `fifo_rd_en`.
- Full-rate burst: FIFO preloaded with 0x0001..0x0008, `m_ready=1`, `start` with `burst_len=8` at cycle n:
  - `fifo_rd_en` high in cycles n+1..n+8.
  - `m_valid` high in cycles n+3..n+10 carrying 0x0001..0x0008 in order.
  - `done` high in n+11; `words_read=8`; FIFO `underflow` never asserted.
- Backpressure: 6 words preloaded, `burst_len=6`, `m_ready=0`:
  - Exactly 2 `fifo_rd_en` pulses; `m_data=0x0001` stable.
  - Then toggle `m_ready` 1/0 → all 6 words delivered in order, no duplicates.
- Empty stall: FIFO empty, `start` with `burst_len=3` → `busy=1`, `fifo_rd_en=0`. The writer pushes 0xA, 0xB, 0xC → those words delivered, then the `done` pulse.
- Underflow injection: force `fifo_underflow=1` on the cycle after the first read of a 4-word burst:
  - `err_underflow=1` and stays set.
  - The dropped word is re-read; 4 words are delivered; `done` pulses.
- Edge cases:
  - `burst_len=0` → `done` in n+1, no reads.
  - `rst` asserted after 3 of 8 words → `m_valid=0`, `busy=0`, `words_read=0` on the next cycle.
  - `start` pulses while `busy` are ignored.

Source files
------------

// File: rtl/fifo_drain_if.sv
// Valid/ready word stream carrying drained FIFO data.
// The master drives data/valid; the slave drives ready.
interface fifo_drain_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fifo_drain.sv
// Read-side controller for the synchronous FIFO: drains a programmed burst and
// re-presents it on a valid/ready stream, hiding the FIFO read latency.
//
// state | meaning
// IDLE  | waiting for a start command
// RUN   | issuing reads, capturing words, forwarding them downstream
// DONE  | one-cycle completion pulse, then back to IDLE
module fifo_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  fifo_drain_if.master          m,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           words_read,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [FIFO_WIDTH-1:0] buf0;
  logic [FIFO_WIDTH-1:0] buf1;
  logic                  pop;
  logic                  push;
  logic                  credit_ok;
  logic                  more_needed;
  logic                  burst_end;

  assign m.data  = buf0;
  assign m.valid = (buf_count != 2'd0);
  assign pop     = m.valid && m.ready;
  assign push    = inflight && !fifo_underflow;

  // A new read may only go out if the buffer can still hold it after this
  // cycle's pop, counting the word already on its way from the FIFO.
  assign credit_ok   = ({1'b0, buf_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign more_needed = remaining > LEN_WIDTH'(inflight);
  assign fifo_rd_en  = (state == RUN) && !fifo_empty && more_needed && credit_ok;

  assign burst_end = (remaining == '0) && !inflight &&
                     ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      buf_count     <= 2'd0;
      buf0          <= '0;
      buf1          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_read    <= 16'd0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      done     <= 1'b0;

      if (push) remaining <= remaining - 1'b1;
      if (inflight && fifo_underflow) err_underflow <= 1'b1;
      if (pop) words_read <= words_read + 16'd1;

      // buf0 is always the head; buf1 only ever holds the second word
      case ({push, pop})
        2'b10: begin
          if (buf_count == 2'd0) buf0 <= fifo_data_out;
          else                   buf1 <= fifo_data_out;
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          buf0      <= buf1;
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf0 <= fifo_data_out;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data_out;
          end
        end
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              remaining <= burst_len;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (burst_end) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain with a behavioural FIFO read port and a
// scoreboard of expected stream words.
module tb_fifo_drain;
  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   words_read;
  logic          err_underflow;

  fifo_drain_if #(.WIDTH(W)) m_if ();

  fifo_drain #(.FIFO_WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .burst_len      (burst_len),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m              (m_if),
    .busy           (busy),
    .done           (done),
    .words_read     (words_read),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int cyc = 0;
  int n;
  int rd_count, first_rd, last_rd, bad_rd;
  int valid_count, first_valid, last_valid;
  int done_count, done_cyc;
  bit inject_arm = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rd_count = 0; first_rd = -1; last_rd = -1; bad_rd = 0;
    valid_count = 0; first_valid = -1; last_valid = -1;
    done_count = 0; done_cyc = -1;
  endtask

  // Sample the DUT mid-cycle, then advance the FIFO model past the edge.
  task automatic cycle();
    bit rd_q;
    @(negedge clk);
    if (fifo_rd_en === 1'b1) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (fifo_empty) bad_rd++;
    end
    if (m_if.valid === 1'b1) begin
      valid_count++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
      if (m_if.ready === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_extra_word: observed %0h expected no word", m_if.data);
        end
        if (exp_q.size() != 0) check("sb_data", m_if.data, exp_q.pop_front());
      end
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    rd_q = (fifo_rd_en === 1'b1);
    @(posedge clk);
    #1;
    fifo_underflow = 1'b0;
    if (rd_q) begin
      if (inject_arm) begin
        fifo_underflow = 1'b1;
        inject_arm = 1'b0;
      end else if (fifo_q.size() != 0) begin
        fifo_data_out = fifo_q.pop_front();
      end
    end
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic load(input logic [W-1:0] base, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      fifo_q.push_back(base + W'(i));
      exp_q.push_back(base + W'(i));
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic writer_push(input logic [W-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int i = 0;
    while (done_count == 0 && i < budget) begin
      cycle();
      i++;
    end
    check("done_within_budget", 32'(done_count != 0), 1);
  endtask

  task automatic pulse_start(input logic [LW-1:0] len);
    n = cyc;
    start = 1'b1;
    burst_len = len;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    m_if.ready = 1'b0;
    clear_stats();

    // reset held for two cycles with start asserted
    rst = 1'b1; start = 1'b1; burst_len = 8'd5;
    cycle();
    clear_stats();
    cycle();
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_m_valid", m_if.valid, 0);
    check("rst_m_data", m_if.data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words_read", words_read, 0);
    check("rst_err_underflow", err_underflow, 0);
    rst = 1'b0; start = 1'b0;
    cycle();

    // full-rate burst of 8
    load(16'h0001, 8);
    m_if.ready = 1'b1;
    clear_stats();
    pulse_start(8'd8);
    run_until_done(40);
    cycle(); cycle();
    check("fr_first_rd", first_rd, n + 1);
    check("fr_last_rd", last_rd, n + 8);
    check("fr_rd_count", rd_count, 8);
    check("fr_first_valid", first_valid, n + 3);
    check("fr_last_valid", last_valid, n + 10);
    check("fr_valid_count", valid_count, 8);
    check("fr_done_cyc", done_cyc, n + 11);
    check("fr_done_count", done_count, 1);
    check("fr_words_read", words_read, 8);
    check("fr_err_underflow", err_underflow, 0);
    check("fr_bad_rd", bad_rd, 0);
    check("fr_sb_left", exp_q.size(), 0);

    // backpressure: ready low, then toggled; a start while busy is ignored
    load(16'h0001, 6);
    m_if.ready = 1'b0;
    clear_stats();
    pulse_start(8'd6);
    repeat (4) cycle();
    start = 1'b1; burst_len = 8'd2;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    check("bp_rd_count_stalled", rd_count, 2);
    check("bp_m_valid", m_if.valid, 1);
    check("bp_m_data", m_if.data, 16'h0001);
    check("bp_busy", busy, 1);
    for (int i = 0; i < 60 && done_count == 0; i++) begin
      m_if.ready = i[0];
      cycle();
    end
    m_if.ready = 1'b1;
    cycle(); cycle();
    check("bp_done_count", done_count, 1);
    check("bp_rd_count", rd_count, 6);
    check("bp_words_read", words_read, 14);
    check("bp_sb_left", exp_q.size(), 0);
    check("bp_bad_rd", bad_rd, 0);

    // empty stall, then the writer trickles in three words
    clear_stats();
    pulse_start(8'd3);
    repeat (4) cycle();
    check("es_busy", busy, 1);
    check("es_rd_count", rd_count, 0);
    check("es_m_valid", m_if.valid, 0);
    writer_push(16'h000A); cycle();
    writer_push(16'h000B); cycle();
    writer_push(16'h000C); cycle();
    run_until_done(30);
    cycle();
    check("es_done_count", done_count, 1);
    check("es_rd_count_total", rd_count, 3);
    check("es_words_read", words_read, 17);
    check("es_sb_left", exp_q.size(), 0);
    check("es_bad_rd", bad_rd, 0);

    // underflow injected on the first read of a 4-word burst
    load(16'h0010, 4);
    clear_stats();
    inject_arm = 1'b1;
    pulse_start(8'd4);
    run_until_done(40);
    cycle(); cycle();
    check("uf_err_underflow", err_underflow, 1);
    check("uf_rd_count", rd_count, 5);
    check("uf_done_count", done_count, 1);
    check("uf_words_read", words_read, 21);
    check("uf_sb_left", exp_q.size(), 0);

    // zero-length burst
    clear_stats();
    pulse_start(8'd0);
    cycle(); cycle();
    check("z_done_cyc", done_cyc, n + 1);
    check("z_done_count", done_count, 1);
    check("z_rd_count", rd_count, 0);
    check("z_err_sticky", err_underflow, 1);
    check("z_words_read", words_read, 21);

    // reset after three of eight words
    load(16'h0021, 8);
    clear_stats();
    pulse_start(8'd8);
    for (int i = 0; i < 30 && words_read != 16'd24; i++) cycle();
    check("rb_three_words", words_read, 24);
    rst = 1'b1;
    cycle();
    check("rb_m_valid", m_if.valid, 0);
    check("rb_busy", busy, 0);
    check("rb_words_read", words_read, 0);
    check("rb_rd_en", fifo_rd_en, 0);
    check("rb_err_underflow", err_underflow, 0);
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    clear_stats();
    repeat (3) cycle();
    check("rb_idle_rd_count", rd_count, 0);
    check("rb_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
